// File: rtl/scan_inject_ctrl.sv
// Fault-injection sequencer for a single mux-scan chain: runs the design functionally
// for a programmed delay, then rotates the chain once and corrupts one selected flip-flop.
module scan_inject_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int POS_W     = 6,
    parameter int DLY_W     = 16
) (
    input  logic             CK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [POS_W-1:0] INJ_POS,
    input  logic [1:0]       INJ_MODE,
    input  logic [DLY_W-1:0] DELAY,
    input  logic             SO,
    output logic             SE,
    output logic             SI,
    output logic             BUSY,
    output logic             DONE,
    output logic             ORIG_BIT,
    output logic             ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_FIN
    } state_t;

    // One extra bit so CHAIN_LEN == 2**POS_W still compares correctly.
    localparam logic [POS_W:0]   LEN_EXT = (POS_W + 1)'(CHAIN_LEN);
    localparam logic [POS_W-1:0] LAST_K  = POS_W'(CHAIN_LEN - 1);

    state_t             state;
    logic [POS_W-1:0]   pos_q;
    logic [1:0]         mode_q;
    logic [DLY_W-1:0]   dly_cnt;
    logic [POS_W-1:0]   k_cnt;
    logic               hit;

    function automatic logic inject_bit(input logic [1:0] mode, input logic so_bit);
        logic r;
        case (mode)
            2'b00:   r = ~so_bit;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = so_bit;
        endcase
        return r;
    endfunction

    assign hit = (state == S_SHIFT) && (k_cnt == pos_q);

    // The rotation path is combinational so the bit leaving SO re-enters SI on the same edge.
    always_comb begin
        SI = 1'b0;
        if (state == S_SHIFT) begin
            SI = hit ? inject_bit(mode_q, SO) : SO;
        end
    end

    always_ff @(posedge CK) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            pos_q    <= '0;
            mode_q   <= '0;
            dly_cnt  <= '0;
            k_cnt    <= '0;
            SE       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ORIG_BIT <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pos_q    <= INJ_POS;
                        mode_q   <= INJ_MODE;
                        ERR      <= 1'b0;
                        ORIG_BIT <= 1'b0;
                        BUSY     <= 1'b1;
                        if ({1'b0, INJ_POS} >= LEN_EXT) begin
                            ERR   <= 1'b1;
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else if (DELAY != '0) begin
                            dly_cnt <= DELAY;
                            state   <= S_WAIT;
                        end else begin
                            k_cnt <= '0;
                            SE    <= 1'b1;
                            state <= S_SHIFT;
                        end
                    end
                end

                // Counter reaches 1 on the last of DELAY wait cycles, so the full range never wraps.
                S_WAIT: begin
                    if (dly_cnt == DLY_W'(1)) begin
                        dly_cnt <= '0;
                        k_cnt   <= '0;
                        SE      <= 1'b1;
                        state   <= S_SHIFT;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (hit) begin
                        ORIG_BIT <= SO;
                    end
                    if (k_cnt == LAST_K) begin
                        k_cnt <= '0;
                        SE    <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        k_cnt <= k_cnt + POS_W'(1);
                    end
                end

                S_FIN: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    SE    <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_inject_ctrl.sv
// Directed bench for scan_inject_ctrl driving a behavioural 8-FF scan chain
// (bit 0 is the FF driving SO; the chain increments while functionally running).
module tb_scan_inject_ctrl;

    localparam int CL = 8;
    localparam int PW = 4;
    localparam int DW = 16;

    logic          CK = 1'b0;
    logic          RESETN;
    logic          START;
    logic [PW-1:0] INJ_POS;
    logic [1:0]    INJ_MODE;
    logic [DW-1:0] DELAY;
    logic          SO, SE, SI, BUSY, DONE, ORIG_BIT, ERR;

    logic [7:0]    chain;
    logic          ld;
    logic [7:0]    ld_val;

    int pass_cnt = 0;
    int total_cnt = 0;

    scan_inject_ctrl #(.CHAIN_LEN(CL), .POS_W(PW), .DLY_W(DW)) dut (
        .CK(CK), .RESETN(RESETN), .START(START), .INJ_POS(INJ_POS),
        .INJ_MODE(INJ_MODE), .DELAY(DELAY), .SO(SO), .SE(SE), .SI(SI),
        .BUSY(BUSY), .DONE(DONE), .ORIG_BIT(ORIG_BIT), .ERR(ERR)
    );

    always #5 CK = ~CK;

    assign SO = chain[0];

    // Scan shifts toward SO; functional mode is a simple counter running while the op waits.
    always @(posedge CK) begin
        if (ld) chain <= ld_val;
        else if (SE) chain <= {SI, chain[7:1]};
        else if (BUSY && !DONE) chain <= chain + 8'd1;
    end

    typedef struct {
        logic [7:0]  pre;
        logic [3:0]  pos;
        logic [1:0]  mode;
        logic [15:0] dly;
        int          glitch;
        logic [7:0]  exp_chain;
        logic        exp_orig;
        int          exp_busy;
        int          exp_se;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge CK);
        ld = 1'b1;
        ld_val = v;
        @(negedge CK);
        ld = 1'b0;
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int busy_c, se_c, done_c, first_se, si_bad;
        logic err_d, tmo;
        busy_c = 0; se_c = 0; done_c = 0; first_se = 0; si_bad = 0;
        err_d = 1'b0; tmo = 1'b1;
        load(v.pre);
        @(negedge CK);
        START = 1'b1; INJ_POS = v.pos; INJ_MODE = v.mode; DELAY = v.dly;
        @(negedge CK);
        // Scramble the request inputs so any late sampling shows up.
        INJ_POS = v.pos ^ 4'd5; INJ_MODE = ~v.mode; DELAY = 16'd7;
        for (int n = 1; n <= 70000; n++) begin
            START = (n == v.glitch);
            if (n == v.glitch) begin
                INJ_POS = 4'd5; INJ_MODE = 2'b00; DELAY = 16'd3;
            end
            if (!BUSY) begin
                tmo = 1'b0;
                break;
            end
            busy_c++;
            if (SE) begin
                se_c++;
                if (first_se == 0) first_se = n;
            end else if (SI !== 1'b0) begin
                si_bad++;
            end
            if (DONE) begin
                done_c++;
                err_d = ERR;
            end
            @(negedge CK);
        end
        START = 1'b0;
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_chain"}, chain, v.exp_chain);
        check({tag, "_orig"}, ORIG_BIT, v.exp_orig);
        check({tag, "_busy_cycles"}, busy_c, v.exp_busy);
        check({tag, "_se_cycles"}, se_c, v.exp_se);
        check({tag, "_first_se"}, first_se, (v.exp_se != 0) ? int'(v.dly) + 1 : 0);
        check({tag, "_done_pulses"}, done_c, 1);
        check({tag, "_err"}, err_d, v.exp_err);
        check({tag, "_si_idle"}, si_bad, 0);
        @(negedge CK);
        check({tag, "_no_reaccept"}, BUSY, 0);
    endtask

    initial begin
        vec_t rv;
        //            pre    pos  mode  dly      gl  exp    orig busy   se err
        vecs[0]  = '{8'hA5, 4'd0,  2'd3, 16'd0,     0, 8'hA5, 1'b1, 9,     8, 1'b0};
        vecs[1]  = '{8'hA5, 4'd0,  2'd0, 16'd0,     0, 8'hA4, 1'b1, 9,     8, 1'b0};
        vecs[2]  = '{8'hA5, 4'd7,  2'd0, 16'd0,     0, 8'h25, 1'b1, 9,     8, 1'b0};
        vecs[3]  = '{8'h00, 4'd3,  2'd2, 16'd0,     0, 8'h08, 1'b0, 9,     8, 1'b0};
        vecs[4]  = '{8'h08, 4'd3,  2'd1, 16'd0,     0, 8'h00, 1'b1, 9,     8, 1'b0};
        vecs[5]  = '{8'h10, 4'd1,  2'd3, 16'd5,     0, 8'h15, 1'b0, 14,    8, 1'b0};
        vecs[6]  = '{8'h5A, 4'd8,  2'd0, 16'd0,     0, 8'h5A, 1'b0, 1,     0, 1'b1};
        vecs[7]  = '{8'hC3, 4'd6,  2'd1, 16'd2,     0, 8'h85, 1'b1, 11,    8, 1'b0};
        vecs[8]  = '{8'hFF, 4'd15, 2'd2, 16'd0,     0, 8'hFF, 1'b0, 1,     0, 1'b1};
        vecs[9]  = '{8'h00, 4'd2,  2'd2, 16'd0,     3, 8'h04, 1'b0, 9,     8, 1'b0};
        vecs[10] = '{8'h04, 4'd2,  2'd0, 16'd0,     9, 8'h00, 1'b1, 9,     8, 1'b0};
        vecs[11] = '{8'h00, 4'd0,  2'd0, 16'hFFFF,  0, 8'hFE, 1'b1, 65544, 8, 1'b0};

        RESETN = 1'b0; START = 1'b0; INJ_POS = '0; INJ_MODE = '0; DELAY = '0;
        ld = 1'b1; ld_val = 8'hFF;
        repeat (3) @(negedge CK);
        ld = 1'b0;
        check("rst_se", SE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_orig", ORIG_BIT, 0);
        check("rst_err", ERR, 0);
        check("rst_si", SI, 0);
        RESETN = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // START held high: re-accepted after exactly one idle cycle.
        load(8'h00);
        @(negedge CK);
        START = 1'b1; INJ_POS = 4'd0; INJ_MODE = 2'b00; DELAY = 16'd0;
        for (int i = 0; i < 20 && !DONE; i++) @(negedge CK);
        check("b2b_done1", DONE, 1);
        @(negedge CK);
        check("b2b_gap", BUSY, 0);
        @(negedge CK);
        check("b2b_reaccept", BUSY, 1);
        START = 1'b0;
        for (int i = 0; i < 20 && !DONE; i++) @(negedge CK);
        check("b2b_done2", DONE, 1);
        @(negedge CK);
        check("b2b_chain", chain, 8'h00);
        check("b2b_orig", ORIG_BIT, 1);

        // Reset while k = 4 of a rotation.
        load(8'hA5);
        @(negedge CK);
        START = 1'b1; INJ_POS = 4'd0; INJ_MODE = 2'b11; DELAY = 16'd0;
        @(negedge CK);
        START = 1'b0;
        repeat (4) @(negedge CK);
        check("rst_mid_pre_se", SE, 1);
        RESETN = 1'b0;
        @(negedge CK);
        check("rst_mid_se", SE, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_done", DONE, 0);
        check("rst_mid_si", SI, 0);
        RESETN = 1'b1;
        @(negedge CK);
        check("rst_mid_idle", BUSY, 0);
        rv = '{8'h3C, 4'd2, 2'd0, 16'd0, 0, 8'h38, 1'b1, 9, 8, 1'b0};
        run_and_check(rv, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/scan_inject_ctrl.md
Name: scan_inject_ctrl

Overview:
- Fault-injection sequencer for one scan chain built from reset-scan flip-flop cells (SE/SI muxed D input).
- On request, it lets the design run functionally for a programmed number of cycles.
- It then performs one full circular scan rotation (SO fed back to SI) and corrupts exactly one selected flip-flop on the way through.
- The chain returns to its original state except for the injected bit. The block sits between the campaign driver and the chain's SE/SI/SO pins.

Parameters:
- CHAIN_LEN, 32, number of flip-flops in the chain (>=2).
- POS_W, 6, width of INJ_POS; 2^POS_W must exceed CHAIN_LEN-1.
- DLY_W, 16, width of the functional-delay counter.

Ports:
- CK  input  1  clock shared with the scan chain.
- RESETN  input  1  synchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- INJ_POS  input  POS_W  target FF index counted from the scan-out end (0 = FF driving SO).
- INJ_MODE  input  2  00 = invert, 01 = force 0, 10 = force 1, 11 = golden rotation (no corruption).
- DELAY  input  DLY_W  functional cycles before the scan rotation starts.
- SO  input  1  scan-out of the chain's last FF.
- SE  output  1  scan enable to every chain FF.
- SI  output  1  scan-in to the chain's first FF.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle completion pulse.
- ORIG_BIT  output  1  pre-injection value of the target FF.
- ERR  output  1  INJ_POS out of range; qualified by DONE.

Behaviour:
- **Reset** (RESETN=0 at a CK edge): state IDLE; SE=0, BUSY=0, DONE=0, ORIG_BIT=0, ERR=0; all counters cleared.
- Reset mid-SHIFT aborts immediately with SE=0. Chain contents are then undefined, and recovering them is the driver's job.
- **States:** IDLE, WAIT, SHIFT, FIN.
- **IDLE:**
  - START=1 at an edge latches INJ_POS, INJ_MODE and DELAY; BUSY=1 from the next cycle.
  - If the latched INJ_POS >= CHAIN_LEN, go to FIN with ERR=1 and no shift.
  - Otherwise go to WAIT if DELAY>0, else to SHIFT.
  - START while BUSY=1 is ignored; it is neither queued nor able to alter the latched values.
- **WAIT:**
  - SE=0, so the design runs functionally.
  - The down-counter, loaded with DELAY, decrements each cycle.
  - Exactly DELAY cycles are spent in WAIT, then the block enters SHIFT.
- **SHIFT:**
  - SE=1 for exactly CHAIN_LEN consecutive cycles. Shift counter k runs 0..CHAIN_LEN-1.
  - SI is combinational from SO: SI = SO for k != INJ_POS.
  - At k == INJ_POS: SI = ~SO (mode 00), 0 (mode 01), 1 (mode 10), SO (mode 11).
  - At k == INJ_POS, ORIG_BIT is registered from SO and holds until the next accepted START.
  - After the cycle with k = CHAIN_LEN-1, go to FIN.
- **FIN:**
  - SE=0; DONE=1 for this single cycle; BUSY stays 1 in FIN.
  - Next state is IDLE, where BUSY=0.
  - ERR holds until the next accepted START, where it is cleared.
- **SI outside SHIFT:** 0.
- **Latency:** from the accepting START edge, BUSY is high for DELAY + CHAIN_LEN + 1 cycles. The error path takes 1 cycle.
- **Boundaries:**
  - DELAY=0 skips WAIT.
  - DELAY = 2^DLY_W-1 is legal and must not wrap early.
  - INJ_POS = CHAIN_LEN-1 corrupts on the final shift cycle.
  - START asserted in the FIN cycle is ignored. START held high is re-accepted in IDLE, giving back-to-back operations one IDLE cycle apart.
- **Invariant:** after any non-error operation, the chain equals the pre-rotation state, with FF[INJ_POS] modified per INJ_MODE.

Test Plan:
- Golden rotation (CHAIN_LEN=8, behavioural 8-FF chain preloaded 0xA5, mode 11, DELAY=0) -> SE high for exactly 8 cycles; chain == 0xA5 afterwards; DONE a single pulse 9 cycles after START.
- Invert (0xA5, INJ_POS=0, mode 00) -> SO-end FF flipped; chain 0xA4 with bit0 = SO-end; ORIG_BIT=1. Repeat with INJ_POS=7 -> 0x25, ORIG_BIT=1.
- Force modes (chain 0x00, INJ_POS=3, mode 10) -> 0x08, ORIG_BIT=0. Then mode 01 at the same position -> 0x00, ORIG_BIT=1.
- Delay (DELAY=5) -> SE=0 for exactly 5 cycles after BUSY rises; chain clocks functionally; BUSY high for 14 cycles.
- Error/ignore (INJ_POS=8) -> no SE assertion, DONE+ERR 1 cycle after START. Separately, a START pulse mid-SHIFT changes nothing.
- Reset mid-op (RESETN low at k=4, then released) -> SE, BUSY, DONE at 0 at the next edge; state IDLE; a fresh START completes normally.
